// File: rtl/sp_ram_responder_if.sv
// sp_ram_intf: single-port buffer access bus between a compute-side master
// and a memory responder.
//   cs      access select
//   oe      read enable
//   addr    word address
//   W_req   active-low byte write enables (lane i writes when W_req[i]=0)
//   W_data  write data
//   R_data  read data returned by the memory side
interface sp_ram_intf #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                      cs;
    logic                      oe;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH/8-1:0]   W_req;
    logic [DATA_WIDTH-1:0]     W_data;
    logic [DATA_WIDTH-1:0]     R_data;

    modport master (
        output cs, oe, addr, W_req, W_data,
        input  R_data
    );

    modport memory (
        input  cs, oe, addr, W_req, W_data,
        output R_data
    );
endinterface

// File: rtl/sp_ram_responder.sv
// sp_ram_responder: memory side of sp_ram_intf modelling one on-chip EPU
// buffer. Registered reads, byte-masked writes, out-of-range guard and a
// zero-fill sequencer that clears the array after reset or on request.
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   clear_i     one-cycle request to zero-fill the array
//   mem         sp_ram_intf memory modport (cs, oe, addr, W_req, W_data / R_data)
//   busy_o      high while the zero-fill runs; accesses are ignored
//   oob_o       one-cycle pulse after an access addressed >= DEPTH
//   conflict_o  one-cycle pulse after oe=1 combined with a write strobe
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing zero to ram[clr_addr] each cycle, accesses ignored
// ST_IDLE  | servicing reads/writes from the bus
module sp_ram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int OUT_REG    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    sp_ram_intf.memory mem,
    output logic       busy_o,
    output logic       oob_o,
    output logic       conflict_o
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       clr_addr;
    logic [DATA_WIDTH-1:0]  ram [DEPTH];

    logic                   idle;
    logic                   any_wr;
    logic                   in_oob;
    logic [IDX_W-1:0]       idx;
    logic                   acc;
    logic                   rd_launch;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic [DATA_WIDTH-1:0]  rd_pipe;
    logic                   rd_pipe_vld;

    logic                   we;
    logic [IDX_W-1:0]       widx;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [LANES-1:0]       wmask;

    assign idle      = (state == ST_IDLE);
    assign any_wr    = ~&mem.W_req;
    assign in_oob    = {1'b0, mem.addr} >= DEPTH_EXT;
    assign idx       = mem.addr[IDX_W-1:0];
    assign acc       = idle & mem.cs;
    // A write strobe always wins over oe, so a conflicting access launches no read.
    assign rd_launch = acc & mem.oe & ~any_wr;
    assign rd_word   = in_oob ? '0 : ram[idx];

    // Single write port shared by the zero-fill and bus writes.
    always_comb begin
        we    = 1'b0;
        widx  = idx;
        wdata = mem.W_data;
        wmask = '0;
        if (state == ST_CLEAR) begin
            we    = 1'b1;
            widx  = clr_addr;
            wdata = '0;
            wmask = '1;
        end else if (mem.cs && any_wr && !in_oob) begin
            we    = 1'b1;
            wmask = ~mem.W_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    ram[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_addr    <= '0;
            busy_o      <= 1'b1;
            oob_o       <= 1'b0;
            conflict_o  <= 1'b0;
            rd_pipe     <= '0;
            rd_pipe_vld <= 1'b0;
            mem.R_data  <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_IDX) begin
                        state    <= ST_IDLE;
                        clr_addr <= '0;
                        busy_o   <= 1'b0;
                    end
                end
                default: begin
                    if (clear_i) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                        busy_o   <= 1'b1;
                    end
                end
            endcase

            oob_o      <= acc & in_oob;
            conflict_o <= acc & mem.oe & any_wr;

            // The second stage keeps draining even in ST_CLEAR so a read
            // launched just before a clear still returns its data.
            rd_pipe_vld <= rd_launch;
            if (rd_launch) begin
                rd_pipe <= rd_word;
            end

            if (OUT_REG == 0) begin
                if (rd_launch) begin
                    mem.R_data <= rd_word;
                end
            end else if (rd_pipe_vld) begin
                mem.R_data <= rd_pipe;
            end
        end
    end
endmodule

// File: tb/tb_sp_ram_responder.sv
module tb_sp_ram_responder;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          clear_i = 1'b0;
    logic          cs      = 1'b0;
    logic          oe      = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [3:0]    w_req   = 4'hF;
    logic [DW-1:0] w_data  = '0;

    logic busy0, busy1, oob0, oob1, conf0, conf1;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] model [DEPTH];

    always #5 clk = ~clk;

    sp_ram_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    sp_ram_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.cs     = cs;
    assign bus0.oe     = oe;
    assign bus0.addr   = addr;
    assign bus0.W_req  = w_req;
    assign bus0.W_data = w_data;
    assign bus1.cs     = cs;
    assign bus1.oe     = oe;
    assign bus1.addr   = addr;
    assign bus1.W_req  = w_req;
    assign bus1.W_data = w_data;

    sp_ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_i),
        .mem        (bus0),
        .busy_o     (busy0),
        .oob_o      (oob0),
        .conflict_o (conf0)
    );

    sp_ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_i),
        .mem        (bus1),
        .busy_o     (busy1),
        .oob_o      (oob1),
        .conflict_o (conf1)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cs    = 1'b0;
        oe    = 1'b0;
        w_req = 4'hF;
    endtask

    task automatic wr(input int a, input logic [3:0] req, input logic [DW-1:0] d);
        cs     = 1'b1;
        oe     = 1'b0;
        addr   = AW'(a);
        w_req  = req;
        w_data = d;
        step();
        idle_bus();
    endtask

    task automatic rd(input string tag, input int a, input logic [DW-1:0] exp);
        cs    = 1'b1;
        oe    = 1'b1;
        w_req = 4'hF;
        addr  = AW'(a);
        step();
        check({tag, "_lat1"}, bus0.R_data, exp);
        idle_bus();
        step();
        check({tag, "_lat2"}, bus1.R_data, exp);
    endtask

    // Back-to-back reads of every address; OUT_REG=1 lags by one cycle.
    task automatic sweep(input string tag);
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) begin
                cs    = 1'b1;
                oe    = 1'b1;
                w_req = 4'hF;
                addr  = AW'(i);
            end else begin
                idle_bus();
            end
            step();
            if (i < DEPTH) check({tag, "_r0"}, bus0.R_data, model[i]);
            if (i > 0)     check({tag, "_r1"}, bus1.R_data, model[i-1]);
        end
    endtask

    // Counts samples with busy high, starting from the current one.
    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy0 && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int bad_flags;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        rst = 1'b1;
        repeat (3) step();
        check("rst_rdata0", bus0.R_data, 32'h0);
        check("rst_rdata1", bus1.R_data, 32'h0);
        check("rst_busy",   busy0, 1'b1);
        check("rst_oob",    oob0, 1'b0);
        check("rst_conf",   conf0, 1'b0);
        rst = 1'b0;
        busy_len(cnt);
        check("init_busy_len", cnt, 16);
        check("init_busy1_low", busy1, 1'b0);
        sweep("init_zero");

        wr(5, 4'b0000, 32'hDEADBEEF);
        model[5] = 32'hDEADBEEF;
        rd("full_wr", 5, 32'hDEADBEEF);

        wr(5, 4'b1010, 32'h11223344);
        model[5] = 32'hDE22BE44;
        rd("part_wr", 5, 32'hDE22BE44);

        cs = 1'b1; oe = 1'b0; addr = AW'(16); w_req = 4'b0000; w_data = 32'hFFFFFFFF;
        step();
        check("oob_pulse", oob0, 1'b1);
        check("oob_pulse1", oob1, 1'b1);
        idle_bus();
        step();
        check("oob_once", oob0, 1'b0);
        rd("oob_rd", 16, 32'h0);
        sweep("after_oob");

        wr(3, 4'b0000, 32'h12345678);
        model[3] = 32'h12345678;
        rd("pre_conf", 5, 32'hDE22BE44);
        cs = 1'b1; oe = 1'b1; addr = AW'(3); w_req = 4'b1110; w_data = 32'h000000AA;
        step();
        check("conf_pulse", conf0, 1'b1);
        check("conf_hold0", bus0.R_data, 32'hDE22BE44);
        idle_bus();
        step();
        check("conf_once", conf0, 1'b0);
        check("conf_hold1", bus1.R_data, 32'hDE22BE44);
        model[3] = 32'h123456AA;
        rd("conf_wr", 3, 32'h123456AA);

        wr(2, 4'b0000, 32'h1);
        model[2] = 32'h1;
        cs = 1'b1; oe = 1'b1; w_req = 4'hF; addr = AW'(2); clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("clr_rd0", bus0.R_data, 32'h1);
        check("clr_busy", busy0, 1'b1);
        cs = 1'b1; oe = 1'b1; w_req = 4'b0000; addr = AW'(7); w_data = 32'hFFFFFFFF;
        step();
        check("clr_rd1_inflight", bus1.R_data, 32'h1);
        cnt = 1;
        bad_flags = 0;
        while (busy0 && cnt < 100) begin
            if (conf0 || oob0 || conf1 || oob1) bad_flags++;
            cnt++;
            step();
        end
        idle_bus();
        check("clr_busy_len", cnt, 16);
        check("clr_no_flags", bad_flags, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        sweep("after_clr");

        wr(9, 4'b0000, 32'hCAFEF00D);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", busy0, 1'b1);
        check("rst_mid_rdata", bus0.R_data, 32'h0);
        busy_len(cnt);
        check("rst_mid_busy_len", cnt, 16);
        rd("rst_mid_rd", 9, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sp_ram_responder.md
Name: sp_ram_responder

Overview:
- Memory-side responder for `sp_ram_intf`. It implements the `memory` modport that compute-side masters drive through the EPU buffer path.
- It models one on-chip single-port buffer (EPU input or output buffer):
  - registered reads;
  - byte-masked writes;
  - an out-of-range guard;
  - a zero-fill sequencer that clears the array after reset or on request, so ping-pong buffers start each layer clean.

Parameters:
- `ADDR_WIDTH`, 12, width of `addr`.
- `DATA_WIDTH`, 32, width of `W_data`/`R_data`; multiple of 8.
- `DEPTH`, 4096, number of words; must be ≤ 2**`ADDR_WIDTH`.
- `OUT_REG`, 0, 1 adds an output register stage (read latency 2 instead of 1).

Ports:
- `clk`  input  1  clock; everything on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `clear_i`  input  1  one-cycle request to zero-fill the whole array.
- `mem`  modport `sp_ram_intf.memory`  –  inputs `cs`, `oe`, `addr[ADDR_WIDTH]`, `W_req[DATA_WIDTH/8]`, `W_data[DATA_WIDTH]`; output `R_data[DATA_WIDTH]`.
- `busy_o`  output  1  high while the zero-fill runs; accesses are ignored.
- `oob_o`  output  1  one-cycle pulse: an access addressed ≥ `DEPTH`.
- `conflict_o`  output  1  one-cycle pulse: `oe`=1 together with any active write strobe.

Behaviour:
- Reset values:
  - `R_data`=0, `busy_o`=1, `oob_o`=0, `conflict_o`=0.
  - FSM enters CLEAR with `clr_addr`=0.
  - Reset asserted mid-CLEAR restarts the fill from address 0.
- FSM states: CLEAR, IDLE.
  - CLEAR:
    - Writes 0 to `mem[clr_addr]` each cycle and increments `clr_addr`.
    - After writing `DEPTH`-1, goes to IDLE next cycle.
    - The fill takes exactly `DEPTH` cycles; `busy_o`=1 throughout.
  - IDLE:
    - `busy_o`=0.
    - `clear_i`=1 moves to CLEAR next cycle with `clr_addr`=0.
    - An access sampled in that same cycle is still serviced.
  - `clear_i` while in CLEAR is ignored; the fill does not restart.
- Access decode (IDLE only, sampled at posedge):
  - Access = `cs`=1.
  - Write = any `W_req` bit 0. `W_req` is an active-low byte enable: lane i updates when `W_req[i]`=0.
  - Read = `oe`=1 and all `W_req` bits 1.
  - `cs`=0: no action, `R_data` holds.
- Write:
  - Enabled byte lanes of `mem[addr]` update at the sampling edge; other lanes keep their value.
  - No write-through to `R_data`.
- Read:
  - `R_data` = `mem[addr]` valid 1 cycle after sampling (`OUT_REG`=0) or 2 cycles (`OUT_REG`=1).
  - Back-to-back reads are fully pipelined, one per cycle.
  - `R_data` holds its last value until the next read completes.
- Conflict (`cs`=1, `oe`=1, any `W_req` bit 0):
  - The write wins and lanes update.
  - No read is launched and `R_data` holds.
  - `conflict_o` pulses 1 cycle after sampling.
- Out of range (`addr` ≥ `DEPTH`, `cs`=1):
  - Write is dropped with no wrap-around.
  - Read returns 0 with normal latency.
  - `oob_o` pulses 1 cycle after sampling.
- During CLEAR:
  - Any `cs` access is ignored: no write, no read launch, `R_data` holds.
  - `oob_o` and `conflict_o` stay 0.
  - With `OUT_REG`=1, a read already in flight when CLEAR starts still completes.

Test Plan:
- Reset with `DEPTH`=16 → `busy_o`=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0.
- Full word at `addr`=5, then read 5:
  - Write: `W_req`=4'b0000, `W_data`=32'hDEADBEEF.
  - Read: `cs`=1, `oe`=1, `W_req`=4'hF.
  - → `R_data`=32'hDEADBEEF one cycle later; with `OUT_REG`=1, two cycles later.
- Partial write to `addr`=5 (holding DEADBEEF): `W_req`=4'b1010, `W_data`=32'h11223344 → read returns 32'hDE22BE44.
- OOB write at `addr`=16 (`DEPTH`=16) → `oob_o` pulses once. A read at 16 returns 0. The array is unchanged (checked by reading 0..15).
- Conflict at `addr`=3: `oe`=1, `W_req`=4'b1110, `W_data`=32'hAA → byte0 becomes 8'hAA, `R_data` unchanged, `conflict_o` pulses once.
- Clear mid-operation:
  - Fill `addr`=2 with 32'h1, then pulse `clear_i` together with a read of 2.
  - → Read returns 32'h1, then `busy_o`=1 for `DEPTH` cycles.
  - Writes issued during busy are dropped.
  - Afterwards every address reads 0.
  - Assert `rst` mid-clear → `busy_o` lasts a fresh `DEPTH` cycles.
